// File: rtl/rv32i_types.sv
// Shared types for the instruction-side cache: FSM state encoding and line geometry.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2
  } imem_cache_state_t;

  localparam int LINE_WORDS  = 8;
  localparam int OFFSET_BITS = 5;

endpackage

// File: rtl/icache_line_array.sv
// Flop-based valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read by index, one synchronous write port; only valid bits are reset.
module icache_line_array
  import rv32i_types::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int TAG_BITS   = 23,
  parameter int LINE_BITS  = 256,
  parameter int INDEX_BITS = $clog2(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [LINE_BITS-1:0]  rd_line,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [LINE_BITS-1:0]  wr_line
);

  logic [NUM_SETS-1:0]  valid_reg;
  logic [TAG_BITS-1:0]  tag_reg  [NUM_SETS];
  logic [LINE_BITS-1:0] data_reg [NUM_SETS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SETS; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (wr_en && (wr_index == INDEX_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag and data need no reset: they are never consulted while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_reg[wr_index]  <= wr_tag;
      data_reg[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_reg[rd_index];
  assign rd_line  = data_reg[rd_index];

endmodule

// File: rtl/imem_line_cache.sv
// Read-only direct-mapped instruction cache: one 32-bit word per accepted fetch request,
// whole-line refill over a single-beat backing-memory port.
module imem_line_cache
  import rv32i_types::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    imem_req,
  input  logic [31:0]             imem_addr,
  input  logic [3:0]              imem_rmask,
  output logic                    imem_resp,
  output logic [31:0]             imem_rdata,
  output logic                    dfp_read,
  output logic [31:0]             dfp_addr,
  input  logic [LINE_BYTES*8-1:0] dfp_rdata,
  input  logic                    dfp_resp
);

  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS   = 32 - OFFSET_BITS - INDEX_BITS;

  imem_cache_state_t state_reg, state_next;
  logic [31:2]       addr_reg;
  logic              fill_done_reg;

  logic                  accept;
  logic                  hit;
  logic                  latch_en;
  logic                  wr_en;
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic [2:0]            req_offset;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [LINE_BITS-1:0]  rd_line;
  logic [31:0]           line_words [LINE_WORDS];
  logic [1:0]            unused_bits;

  assign unused_bits = imem_addr[1:0];

  assign accept     = imem_req && (imem_rmask != 4'b0000);
  assign req_index  = addr_reg[OFFSET_BITS +: INDEX_BITS];
  assign req_tag    = addr_reg[31 -: TAG_BITS];
  assign req_offset = addr_reg[4:2];
  assign hit        = rd_valid && (rd_tag == req_tag);

  // Requests are only taken when idle or alongside a hit; anything else is dropped.
  assign latch_en = accept && ((state_reg == IDLE) || ((state_reg == LOOKUP) && hit));
  assign wr_en    = (state_reg == FILL) && !fill_done_reg && dfp_resp;

  icache_line_array #(
    .NUM_SETS  (NUM_SETS),
    .TAG_BITS  (TAG_BITS),
    .LINE_BITS (LINE_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_index (req_index),
    .wr_tag   (req_tag),
    .wr_line  (dfp_rdata)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_words
      assign line_words[gi] = rd_line[32*gi +: 32];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      fill_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      // One settle cycle after the line lands keeps refill latency at two cycles.
      fill_done_reg <= wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && latch_en) begin
      addr_reg <= imem_addr[31:2];
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = LOOKUP;
      LOOKUP:  if (!hit) state_next = FILL;
               else if (!accept) state_next = IDLE;
      FILL:    if (fill_done_reg) state_next = LOOKUP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_resp  = 1'b0;
    imem_rdata = '0;
    dfp_read   = 1'b0;
    dfp_addr   = '0;
    if ((state_reg == LOOKUP) && hit) begin
      imem_resp  = 1'b1;
      imem_rdata = line_words[req_offset];
    end
    if ((state_reg == FILL) && !fill_done_reg) begin
      dfp_read = 1'b1;
      dfp_addr = {addr_reg[31:5], 5'b00000};
    end
  end

endmodule

// File: tb/tb_imem_line_cache.sv
// Scoreboard bench for imem_line_cache: a backing-memory model answers refills and every
// imem response is popped against the word expected when its request was issued.
module tb_imem_line_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic [3:0]   imem_rmask;
  logic         imem_resp;
  logic [31:0]  imem_rdata;
  logic         dfp_read;
  logic [31:0]  dfp_addr;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;

  int checks = 0;
  int errors = 0;
  int resp_count = 0;
  int cyc = 0;
  int last_resp_cyc = 0;
  logic [31:0] exp_q[$];

  imem_line_cache #(.NUM_SETS(16), .LINE_BYTES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_resp  (imem_resp),
    .imem_rdata (imem_rdata),
    .dfp_read   (dfp_read),
    .dfp_addr   (dfp_addr),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h1eceb000) return 32'h00000013;
    return (w * 32'h9e3779b1) ^ 32'h0badf00d;
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] a);
    logic [255:0] line;
    logic [31:0]  base;
    base = {a[31:5], 5'b00000};
    for (int i = 0; i < 8; i++) line[32*i +: 32] = model_word(base + 32'(4 * i));
    return line;
  endfunction

  // Response monitor: samples just after each rising edge and pops the scoreboard.
  always @(posedge clk) begin
    logic [31:0] exp_w;
    #1;
    if (imem_resp) begin
      resp_count++;
      last_resp_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got resp with rdata=%h, required no resp", imem_rdata);
      end else begin
        exp_w = exp_q.pop_front();
        if (imem_rdata !== exp_w) begin
          errors++;
          $display("FAIL resp_rdata: got %h, required %h", imem_rdata, exp_w);
        end else begin
          $display("resp cyc=%0d rdata=%h", cyc, imem_rdata);
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, input int expect_miss);
    int   base;
    int   req_cyc;
    int   dfp_cyc;
    logic saw_fill;
    @(negedge clk);
    imem_req   = 1'b1;
    imem_addr  = a;
    imem_rmask = 4'hf;
    exp_q.push_back(model_word(a));
    req_cyc  = cyc;
    dfp_cyc  = 0;
    base     = resp_count;
    saw_fill = 1'b0;
    @(negedge clk);
    imem_req = 1'b0;
    for (int i = 0; i < 40 && resp_count == base; i++) begin
      if (dfp_read && !saw_fill) begin
        saw_fill = 1'b1;
        checks++;
        if (dfp_addr !== {a[31:5], 5'b00000}) begin
          errors++;
          $display("FAIL dfp_addr(%h): got %h, required %h", a, dfp_addr, {a[31:5], 5'b00000});
        end
        dfp_rdata = model_line(a);
        dfp_resp  = 1'b1;
        dfp_cyc   = cyc;
        @(negedge clk);
        dfp_resp  = 1'b0;
        dfp_rdata = '0;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (resp_count == base) begin
      errors++;
      $display("FAIL fetch_timeout(%h): got no resp, required one", a);
    end else if (expect_miss >= 0 && saw_fill !== expect_miss[0]) begin
      errors++;
      $display("FAIL miss_flag(%h): got refill=%0d, required %0d", a, saw_fill, expect_miss);
    end else if (expect_miss == 1 && last_resp_cyc - dfp_cyc != 2) begin
      errors++;
      $display("FAIL miss_latency(%h): got %0d, required 2", a, last_resp_cyc - dfp_cyc);
    end else if (expect_miss == 0 && last_resp_cyc - req_cyc != 1) begin
      errors++;
      $display("FAIL hit_latency(%h): got %0d, required 1", a, last_resp_cyc - req_cyc);
    end
    $display("fetch addr=%h refill=%0d", a, saw_fill);
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    imem_req   = 1'b0;
    imem_addr  = '0;
    imem_rmask = '0;
    dfp_rdata  = '0;
    dfp_resp   = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (imem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b, required 0", imem_resp); end
    if (imem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", imem_rdata); end
    if (dfp_read !== 1'b0) begin errors++; $display("FAIL reset_dfp_read: got %b, required 0", dfp_read); end
    if (dfp_addr !== 32'h0) begin errors++; $display("FAIL reset_dfp_addr: got %h, required 0", dfp_addr); end
    rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_cold_miss();
    do_fetch(32'h1eceb000, 1);
  endtask

  task automatic test_hit_stream();
    int base;
    int req_cyc;
    base = resp_count;
    @(negedge clk);
    req_cyc = cyc;
    for (int i = 1; i <= 3; i++) begin
      imem_req   = 1'b1;
      imem_addr  = 32'h1eceb000 + 32'(4 * i);
      imem_rmask = 4'hf;
      exp_q.push_back(model_word(imem_addr));
      @(negedge clk);
      checks++;
      if (dfp_read !== 1'b0) begin errors++; $display("FAIL stream_dfp_read: got %b, required 0", dfp_read); end
    end
    imem_req = 1'b0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (resp_count != base + 3) begin
      errors++;
      $display("FAIL stream_count: got %0d, required 3", resp_count - base);
    end
    if (last_resp_cyc != req_cyc + 3) begin
      errors++;
      $display("FAIL stream_timing: got last resp at +%0d, required +3", last_resp_cyc - req_cyc);
    end
  endtask

  task automatic test_conflict();
    do_fetch(32'h1eceb000, 0);
    do_fetch(32'h1eced000, 1);
    do_fetch(32'h1eceb000, 1);
  endtask

  task automatic test_masked_and_violation();
    int base;
    base = resp_count;
    @(negedge clk);
    imem_req   = 1'b1;
    imem_addr  = 32'h00000040;
    imem_rmask = 4'h0;
    @(negedge clk);
    imem_req = 1'b0;
    repeat (3) @(negedge clk);
    checks += 2;
    if (resp_count != base) begin errors++; $display("FAIL masked_resp: got %0d resps, required 0", resp_count - base); end
    if (dfp_read !== 1'b0) begin errors++; $display("FAIL masked_dfp_read: got %b, required 0", dfp_read); end

    // Original request misses; extra requests arrive during LOOKUP-miss and FILL.
    base = resp_count;
    imem_req   = 1'b1;
    imem_addr  = 32'h00000104;
    imem_rmask = 4'hf;
    exp_q.push_back(model_word(32'h00000104));
    @(negedge clk);
    imem_addr = 32'h00000208;
    @(negedge clk);
    imem_addr = 32'h0000024c;
    checks++;
    if (dfp_read !== 1'b1 || dfp_addr !== 32'h00000100) begin
      errors++;
      $display("FAIL viol_fill: got read=%b addr=%h, required read=1 addr=00000100", dfp_read, dfp_addr);
    end
    @(negedge clk);
    imem_req  = 1'b0;
    dfp_rdata = model_line(32'h00000100);
    dfp_resp  = 1'b1;
    @(negedge clk);
    dfp_resp  = 1'b0;
    dfp_rdata = '0;
    repeat (5) @(negedge clk);
    checks++;
    if (resp_count != base + 1) begin
      errors++;
      $display("FAIL viol_count: got %0d resps, required 1", resp_count - base);
    end
  endtask

  task automatic test_reset_mid_fill();
    int base;
    base = resp_count;
    @(negedge clk);
    imem_req   = 1'b1;
    imem_addr  = 32'h00000308;
    imem_rmask = 4'hf;
    @(negedge clk);
    imem_req = 1'b0;
    @(negedge clk);
    checks++;
    if (dfp_read !== 1'b1) begin errors++; $display("FAIL midfill_read: got %b, required 1", dfp_read); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dfp_read !== 1'b0) begin errors++; $display("FAIL midfill_drop: got %b, required 0", dfp_read); end
    dfp_rdata = ~model_line(32'h00000300);
    dfp_resp  = 1'b1;
    @(negedge clk);
    dfp_resp  = 1'b0;
    dfp_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (resp_count != base) begin errors++; $display("FAIL midfill_resp: got %0d resps, required 0", resp_count - base); end
    do_fetch(32'h00000308, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int base;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 1023) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        base = resp_count;
        @(negedge clk);
        imem_req   = 1'b1;
        imem_addr  = a;
        imem_rmask = 4'h0;
        @(negedge clk);
        imem_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (resp_count != base) begin errors++; $display("FAIL random_masked(%h): got resp, required none", a); end
      end else begin
        do_fetch(a, -1);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_resps: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_conflict();
    test_masked_and_violation();
    test_reset_mid_fill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
